bus_target_mem: RTL and testbench
=================================

// Module: bus_target_mem
// PURPOSE
//  External-side responder for the CPU bus_if nibble-free 8-bit handshake bus. Decodes the
//  ADDR_HI / ADDR_LO / WRITE / READ phases driven by bus_if into single memory transactions on
//  a valid/ready memory port, and answers every phase with bus_ack.
//  Sits directly downstream of bus_if; used in FPGA/emulation harnesses and in the top-level bench.
// PARAMETERS
//  SYNC_STAGES  2   flops in the bus_req input synchronizer (>=2)
// PORTS
//  Clock clk; reset rst_n, asynchronous, active-low.
//  clk          in   1   system clock
//  rst_n        in   1   async active-low reset
//  bus_req      in   1   handshake request from bus_if (asynchronous to clk)
//  bus_state    in   2   phase: 0=ADDR_HI 1=ADDR_LO 2=WRITE 3=READ; stable while bus_req=1
//  bus_data_in  in   8   address byte or write data; stable while bus_req=1
//  bus_data_out out  8   read data returned to bus_if
//  bus_oe       out  1   1 = this block drives bus_data_out onto the shared bus
//  bus_ack      out  1   handshake acknowledge, registered
//  mem_valid    out  1   memory request valid
//  mem_write    out  1   1=write, 0=read; valid with mem_valid
//  mem_addr     out  16  {addr_hi, addr_lo}
//  mem_wdata    out  8   write data
//  mem_ready    in   1   memory accepts the request (read data valid in the same cycle)
//  mem_rdata    in   8   read data, sampled when mem_valid & mem_ready & !mem_write
//  proto_err    out  1   sticky: phase sequence violation seen
// BEHAVIOUR
//  - Reset (async, any time incl. mid-transaction): bus_ack=0, bus_oe=0, bus_data_out=0,
//    mem_valid=0, mem_write=0, mem_addr=0, mem_wdata=0, proto_err=0, FSM=IDLE, expect=ADDR_HI.
//  - Four-phase handshake: req rise -> ack rise -> req fall -> ack fall. Only the synchronized
//    req (req_s) is used; state/data are sampled on the first clk with req_s=1.
//  - FSM: IDLE --req_s--> DECODE (latch bus_state, bus_data_in)
//     DECODE: ADDR_HI: addr_hi<=data -> ACK | ADDR_LO: addr_lo<=data -> ACK
//             WRITE: mem_valid=1,mem_write=1,mem_wdata=data -> MEM
//             READ : mem_valid=1,mem_write=0 -> MEM
//     MEM: hold mem_valid/mem_write/mem_addr/mem_wdata stable until mem_ready; on handshake
//          drop mem_valid; for READ latch mem_rdata into bus_data_out and set bus_oe=1 -> ACK
//     ACK: bus_ack=1 until req_s=0; then bus_ack=0, bus_oe=0 -> IDLE.
//  - bus_oe rises no later than bus_ack for READ and falls in the same cycle as bus_ack;
//    bus_data_out is held until the next READ.
//  - Latency (mem_ready tied 1): req pin rise -> bus_ack rise = SYNC_STAGES+1 cycles for
//    address phases, SYNC_STAGES+2 for WRITE/READ.
//  - Sequence check: expect ADDR_HI, ADDR_LO, then exactly one WRITE or READ, then ADDR_HI.
//    Out-of-order phase: proto_err<=1 (sticky until reset), phase is still executed and acked
//    (the bus never hangs); expect resynchronizes to the successor of the received phase.
//  - req_s falling while in DECODE/MEM is a protocol error: set proto_err, complete the memory
//    transaction, skip ACK, return to IDLE.
//  - mem_ready asserted while mem_valid=0 is ignored.
// STRUCTURE
//  - Shared package bus_pkg: localparams BUS_ADDR_HI/BUS_ADDR_LO/BUS_WRITE/BUS_READ (2 bits),
//    shared with bus_if so both ends decode bus_state identically.
//  - Sub-module sync_n (SYNC_STAGES-deep async-reset synchronizer, reset value 0) for bus_req.
//  - FSM states (IDLE, DECODE, MEM, ACK) as local encoding inside this module.
// TESTING
//  1. Write: phases ADDR_HI=0x12, ADDR_LO=0x34, WRITE=0xA5, mem_ready=1 -> one cycle of
//     mem_valid=1, mem_write=1, mem_addr=0x1234, mem_wdata=0xA5; three full ack cycles.
//  2. Read with stall: ADDR 0xBEEF, READ, mem_ready low 5 cycles then high with mem_rdata=0x5A
//     -> mem_valid held stable 6 cycles; bus_data_out=0x5A, bus_oe=1 with bus_ack; both drop
//     together after req falls.
//  3. Latency: SYNC_STAGES=2, mem_ready=1 -> bus_ack 3 cycles after req pin rise (ADDR_HI),
//     4 cycles (WRITE); proto_err stays 0 for 100 back-to-back random transactions.
//  4. Sequence error: send ADDR_LO first -> proto_err=1, phase acked, addr_lo updated;
//     following ADDR_HI/ADDR_LO/READ completes normally, proto_err remains 1.
//  5. Early req drop: deassert req during MEM (mem_ready=0) -> proto_err=1, bus_ack never
//     rises, transaction completes on mem_ready, FSM back in IDLE.
//  6. Reset mid-READ (in MEM, bus_oe pending) -> all outputs 0 immediately; next full
//     transaction after reset release works.

Source files
------------

// File: rtl/bus_pkg.sv
// bus_pkg: bus_state phase encoding shared by both ends of the handshake bus
package bus_pkg;
  localparam logic [1:0] BUS_ADDR_HI = 2'd0;
  localparam logic [1:0] BUS_ADDR_LO = 2'd1;
  localparam logic [1:0] BUS_WRITE   = 2'd2;
  localparam logic [1:0] BUS_READ    = 2'd3;
endpackage

// File: rtl/sync_n.sv
// sync_n: STAGES-deep async-reset synchronizer, resets to 0
module sync_n #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '0;
    else r <= {r[STAGES-2:0], d};
  assign q = r[STAGES-1];
endmodule

// File: rtl/bus_target_mem.sv
// bus_target_mem: bus_if handshake responder translating phases into valid/ready memory transactions
module bus_target_mem #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_req,
  input  logic [1:0]  bus_state,
  input  logic [7:0]  bus_data_in,
  output logic [7:0]  bus_data_out,
  output logic        bus_oe,
  output logic        bus_ack,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic        proto_err
);
  import bus_pkg::*;
  typedef enum logic [1:0] {IDLE, DECODE, MEM, ACK} state_t;
  state_t state, state_n;
  logic req_s, addr_ph, seq_bad;
  logic [1:0] ph, expect_ph, expect_n;
  logic [7:0] dat, addr_hi, addr_lo;
  sync_n #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(bus_req), .q(req_s));
  assign addr_ph  = ph == BUS_ADDR_HI || ph == BUS_ADDR_LO;
  assign seq_bad  = !(ph == expect_ph || (expect_ph == BUS_WRITE && ph == BUS_READ));
  assign expect_n = ph == BUS_ADDR_HI ? BUS_ADDR_LO : ph == BUS_ADDR_LO ? BUS_WRITE : BUS_ADDR_HI;
  assign mem_addr = {addr_hi, addr_lo};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // a req drop before ACK still lets the memory side finish, then skips the ack
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = req_s ? DECODE : IDLE;
      DECODE:  state_n = !addr_ph ? MEM : req_s ? ACK : IDLE;
      MEM:     state_n = !mem_ready ? MEM : req_s ? ACK : IDLE;
      ACK:     state_n = req_s ? ACK : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph           <= BUS_ADDR_HI;
      dat          <= '0;
      expect_ph    <= BUS_ADDR_HI;
      addr_hi      <= '0;
      addr_lo      <= '0;
      mem_valid    <= 1'b0;
      mem_write    <= 1'b0;
      mem_wdata    <= '0;
      bus_data_out <= '0;
      bus_ack      <= 1'b0;
      bus_oe       <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      if (state == IDLE && req_s) begin
        ph  <= bus_state;
        dat <= bus_data_in;
      end
      if (state == DECODE) begin
        expect_ph <= expect_n;
        if (ph == BUS_ADDR_HI) addr_hi <= dat;
        if (ph == BUS_ADDR_LO) addr_lo <= dat;
        if (ph == BUS_WRITE) mem_wdata <= dat;
        if (!addr_ph) begin
          mem_valid <= 1'b1;
          mem_write <= ph == BUS_WRITE;
        end
      end
      if (state == MEM && mem_ready) begin
        mem_valid <= 1'b0;
        if (!mem_write) bus_data_out <= mem_rdata;
      end
      if ((state == DECODE && seq_bad) || ((state == DECODE || state == MEM) && !req_s))
        proto_err <= 1'b1;
      bus_ack <= state_n == ACK;
      bus_oe  <= state_n == ACK && (bus_oe || (state == MEM && !mem_write));
    end
endmodule

// File: tb/tb_bus_target_mem.sv
// tb_bus_target_mem: directed + random phases checked against a protocol/memory reference model
module tb_bus_target_mem;
  import bus_pkg::*;
  localparam int SYNC = 2;
  logic clk = 1'b0, rst_n = 1'b0, bus_req = 1'b0;
  logic [1:0] bus_state = 2'd0;
  logic [7:0] bus_data_in = 8'd0, bus_data_out, mem_wdata, mem_rdata = 8'd0;
  logic bus_oe, bus_ack, mem_valid, mem_write, mem_ready = 1'b0, proto_err;
  logic [15:0] mem_addr;
  int n_chk = 0, n_fail = 0;
  logic [7:0] mem [0:65535];
  logic [1:0] m_exp = BUS_ADDR_HI;
  logic m_perr = 1'b0;
  logic [7:0] m_hi = 8'd0, m_lo = 8'd0, m_rd = 8'd0;
  logic e_write = 1'b0;
  logic [15:0] e_addr = 16'd0;
  logic [7:0] e_wdata = 8'd0;
  int stall = 0, vcnt = 0;
  bus_target_mem #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_state(bus_state),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out), .bus_oe(bus_oe),
    .bus_ack(bus_ack), .mem_valid(mem_valid), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // memory responder: stalls `stall` cycles per request, ready is random noise while idle
  always @(negedge clk) begin
    if (mem_valid) begin
      vcnt++;
      chk("mem_write", mem_write, e_write);
      chk("mem_addr", mem_addr, e_addr);
      if (e_write) chk("mem_wdata", mem_wdata, e_wdata);
      if (stall > 0) begin
        mem_ready = 1'b0;
        stall--;
      end else begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr];
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = 8'($urandom);
    end
  end
  task automatic model(input logic [1:0] st, input logic [7:0] d);
    if (!(st == m_exp || (m_exp == BUS_WRITE && st == BUS_READ))) m_perr = 1'b1;
    m_exp = st == BUS_ADDR_HI ? BUS_ADDR_LO : st == BUS_ADDR_LO ? BUS_WRITE : BUS_ADDR_HI;
    if (st == BUS_ADDR_HI) m_hi = d;
    if (st == BUS_ADDR_LO) m_lo = d;
    e_write = st == BUS_WRITE;
    e_addr  = {m_hi, m_lo};
    e_wdata = d;
  endtask
  // latency counts edges after the first edge that samples req high
  task automatic phase(input logic [1:0] st, input logic [7:0] d, input int stall_n);
    int n;
    model(st, d);
    stall = stall_n;
    vcnt = 0;
    @(negedge clk);
    bus_state = st;
    bus_data_in = d;
    bus_req = 1'b1;
    n = 0;
    while (!bus_ack && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ack_rise_timeout", n < 100, 1);
    if (stall_n == 0) chk("latency", n - 1, SYNC + (st[1] ? 2 : 1));
    if (st[1]) chk("mem_valid_cycles", vcnt, stall_n + 1);
    if (st == BUS_WRITE) mem[e_addr] = d;
    if (st == BUS_READ) begin
      m_rd = mem[e_addr];
      chk("oe_with_ack", bus_oe, 1);
    end else chk("oe_idle", bus_oe, 0);
    chk("data_out", bus_data_out, m_rd);
    chk("proto_err", proto_err, m_perr);
    @(negedge clk);
    bus_req = 1'b0;
    n = 0;
    while (bus_ack && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ack_fall_timeout", n < 100, 1);
    chk("oe_drop", bus_oe, 0);
    chk("data_out_held", bus_data_out, m_rd);
  endtask
  task automatic txn(input logic [15:0] a, input logic wr, input logic [7:0] d, input int stall_n);
    phase(BUS_ADDR_HI, a[15:8], 0);
    phase(BUS_ADDR_LO, a[7:0], 0);
    phase(wr ? BUS_WRITE : BUS_READ, d, stall_n);
  endtask
  task automatic check_all_zero(input string tag);
    chk({tag, "_ack"}, bus_ack, 0);
    chk({tag, "_oe"}, bus_oe, 0);
    chk({tag, "_dout"}, bus_data_out, 0);
    chk({tag, "_valid"}, mem_valid, 0);
    chk({tag, "_write"}, mem_write, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_perr"}, proto_err, 0);
  endtask
  task automatic model_reset();
    m_exp = BUS_ADDR_HI;
    m_perr = 1'b0;
    m_hi = 8'd0;
    m_lo = 8'd0;
    m_rd = 8'd0;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    logic saw_ack;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    txn(16'h1234, 1'b1, 8'hA5, 0);
    chk("write_stored", mem[16'h1234], 8'hA5);
    mem[16'hBEEF] = 8'h5A;
    txn(16'hBEEF, 1'b0, 8'h00, 5);
    chk("read_stall_data", bus_data_out, 8'h5A);
    for (int i = 0; i < 100; i++)
      txn(16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), 0);
    chk("random_no_err", proto_err, 0);
    phase(BUS_ADDR_LO, 8'h77, 0);
    chk("seq_err", proto_err, 1);
    phase(BUS_READ, 8'h00, 1);
    txn(16'hC0DE, 1'b0, 8'h00, 2);
    chk("seq_err_sticky", proto_err, 1);
    phase(BUS_ADDR_HI, 8'h42, 0);
    phase(BUS_ADDR_LO, 8'h24, 0);
    model(BUS_WRITE, 8'h99);
    m_perr = 1'b1;
    stall = 1000;
    @(negedge clk);
    bus_state = BUS_WRITE;
    bus_data_in = 8'h99;
    bus_req = 1'b1;
    n = 0;
    while (!mem_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drop_valid_timeout", n < 50, 1);
    bus_req = 1'b0;
    saw_ack = 1'b0;
    repeat (SYNC + 3) begin
      @(negedge clk);
      saw_ack |= bus_ack;
    end
    chk("drop_valid_held", mem_valid, 1);
    stall = 0;
    n = 0;
    while (mem_valid && n < 50) begin
      @(negedge clk);
      saw_ack |= bus_ack;
      n++;
    end
    chk("drop_complete_timeout", n < 50, 1);
    mem[16'h4224] = 8'h99;
    repeat (3) begin
      @(negedge clk);
      saw_ack |= bus_ack;
    end
    chk("drop_no_ack", saw_ack, 0);
    chk("drop_perr", proto_err, 1);
    txn(16'h4224, 1'b0, 8'h00, 0);
    chk("after_drop_read", bus_data_out, 8'h99);
    phase(BUS_ADDR_HI, 8'h5E, 0);
    phase(BUS_ADDR_LO, 8'hA7, 0);
    model(BUS_READ, 8'h00);
    stall = 1000;
    @(negedge clk);
    bus_state = BUS_READ;
    bus_req = 1'b1;
    n = 0;
    while (!mem_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_valid_timeout", n < 50, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    bus_req = 1'b0;
    stall = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    a = 16'h0F0F;
    txn(a, 1'b1, 8'h3C, 0);
    txn(a, 1'b0, 8'h00, 1);
    chk("post_reset_read", bus_data_out, 8'h3C);
    chk("post_reset_perr", proto_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
